// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: walks the character/attribute RAM per scanline,
// fetches glyph rows from the 16-bit font RAM and serialises them MSB first
// into 4-bit colour-index pixels.
module text_pixel_gen #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [15:0] FONT_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        de,
  output logic [15:0] text_addr,
  input  logic [15:0] text_data,
  output logic [15:0] font_addr,
  input  logic [15:0] font_data,
  output logic [3:0]  pix_out,
  output logic        pix_valid
);

  localparam logic [7:0]  COLS_W  = 8'(COLS);
  localparam logic [7:0]  ROWS_W  = 8'(ROWS);
  localparam logic [15:0] COLS_16 = 16'(COLS);

  typedef enum logic [1:0] {
    IDLE,
    TXT,
    FNT,
    CAP
  } state_t;

  state_t      state;

  logic [2:0]  scan;
  logic [7:0]  trow;
  logic [7:0]  col;
  logic [15:0] row_base;
  logic        first_line;
  logic        armed;

  logic [2:0]  scan_n;
  logic [7:0]  trow_n;
  logic [15:0] row_base_n;
  logic        first_line_n;

  logic        buf_full;
  logic [7:0]  buf_bits;
  logic [3:0]  buf_fg;
  logic [3:0]  buf_bg;

  logic [7:0]  sh_bits;
  logic [3:0]  sh_fg;
  logic [3:0]  sh_bg;
  logic [2:0]  pcnt;

  logic        fetch_ok;
  logic        load;
  logic [7:0]  load_bits;
  logic [3:0]  load_fg;
  logic [3:0]  load_bg;

  // Next-state of the line/row counters. frame_start is folded in first so a
  // coincident line_start consumes the fresh first_line flag and stays on scan 0.
  always_comb begin
    scan_n       = frame_start ? 3'd0  : scan;
    trow_n       = frame_start ? 8'd0  : trow;
    row_base_n   = frame_start ? 16'd0 : row_base;
    first_line_n = frame_start ? 1'b1  : first_line;
    if (line_start) begin
      if (first_line_n) begin
        first_line_n = 1'b0;
      end else begin
        if (scan_n == 3'd7) begin
          trow_n     = trow_n + 8'd1;
          row_base_n = row_base_n + COLS_16;
        end
        scan_n = scan_n + 3'd1;
      end
    end
  end

  // Register the counters; armed gates all activity between reset and the next line.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan       <= '0;
      trow       <= '0;
      row_base   <= '0;
      first_line <= 1'b1;
      armed      <= 1'b0;
    end else begin
      scan       <= scan_n;
      trow       <= trow_n;
      row_base   <= row_base_n;
      first_line <= first_line_n;
      if (line_start) begin
        armed <= 1'b1;
      end
    end
  end

  // Fetch eligibility, and the shifter pulling the next cell from the buffer.
  always_comb begin
    fetch_ok  = armed && !buf_full && (col < COLS_W) && (trow < ROWS_W);
    load      = armed && de && (pcnt == 3'd0) && !line_start;
    load_bits = buf_full ? buf_bits : '0;
    load_fg   = buf_full ? buf_fg   : '0;
    load_bg   = buf_full ? buf_bg   : '0;
  end

  // Fetch FSM: text RAM -> font RAM address -> glyph row into the one-cell buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      text_addr <= '0;
      font_addr <= '0;
      col       <= '0;
      buf_full  <= 1'b0;
      buf_bits  <= '0;
      buf_fg    <= '0;
      buf_bg    <= '0;
    end else if (line_start) begin
      state    <= IDLE;
      col      <= '0;
      buf_full <= 1'b0;
    end else begin
      // A shifter load only empties the buffer; a same-cycle CAP can only occur
      // when the buffer was already empty, so CAP's assignment below wins.
      if (load) begin
        buf_full <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (fetch_ok) begin
            text_addr <= row_base + {8'd0, col};
            state     <= TXT;
          end
        end
        TXT: begin
          font_addr <= FONT_BASE + {6'd0, text_data[7:0], scan[2:1]};
          buf_fg    <= text_data[11:8];
          buf_bg    <= text_data[15:12];
          state     <= FNT;
        end
        FNT: begin
          state <= CAP;
        end
        CAP: begin
          buf_bits <= scan[0] ? font_data[7:0] : font_data[15:8];
          buf_full <= 1'b1;
          col      <= col + 8'd1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pixel shifter: one pixel per de, reloading from the buffer every 8 pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt      <= '0;
      sh_bits   <= '0;
      sh_fg     <= '0;
      sh_bg     <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= de && armed;
      if (line_start) begin
        pcnt    <= '0;
        sh_bits <= '0;
        sh_fg   <= '0;
        sh_bg   <= '0;
        pix_out <= '0;
      end else if (de && armed) begin
        pcnt <= pcnt + 3'd1;
        if (pcnt == 3'd0) begin
          pix_out <= load_bits[7] ? load_fg : load_bg;
          sh_bits <= {load_bits[6:0], 1'b0};
          sh_fg   <= load_fg;
          sh_bg   <= load_bg;
        end else begin
          pix_out <= sh_bits[7] ? sh_fg : sh_bg;
          sh_bits <= {sh_bits[6:0], 1'b0};
        end
      end else begin
        pix_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen with behavioural text and font RAMs.
module tb_text_pixel_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        de = 1'b0;
  logic [15:0] text_addr;
  logic [15:0] text_data;
  logic [15:0] font_addr;
  logic [15:0] font_data;
  logic [3:0]  pix_out;
  logic        pix_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] text_mem [0:4095];
  logic [15:0] font_mem [0:1023];

  // Per-line history, index k = negedge count after the line_start negedge
  logic [15:0] ta_h [0:699];
  logic [15:0] fa_h [0:699];
  logic [3:0]  px_h [0:699];
  logic        pv_h [0:699];

  always #5 clk = ~clk;

  assign text_data = text_mem[text_addr[11:0]];

  always @(posedge clk) font_data <= font_mem[font_addr[9:0]];

  text_pixel_gen #(
    .COLS(80),
    .ROWS(30),
    .FONT_BASE(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .line_start(line_start),
    .de(de),
    .text_addr(text_addr),
    .text_data(text_data),
    .font_addr(font_addr),
    .font_data(font_data),
    .pix_out(pix_out),
    .pix_valid(pix_valid)
  );

  function automatic logic [3:0] exp_pix(input logic [15:0] tw, input logic [2:0] sc, input int i);
    logic [9:0]  fa;
    logic [15:0] fw;
    logic [7:0]  bits;
    fa   = {tw[7:0], sc[2:1]};
    fw   = font_mem[fa];
    bits = sc[0] ? fw[7:0] : fw[15:8];
    return bits[7-i] ? tw[11:8] : tw[15:12];
  endfunction

  task automatic drive_line(input int nde, input logic fs, input int rst_at);
    int last;
    last = 9 + nde;
    @(negedge clk);
    line_start  = 1'b1;
    frame_start = fs;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      ta_h[k] = text_addr;
      fa_h[k] = font_addr;
      px_h[k] = pix_out;
      pv_h[k] = pix_valid;
      line_start  = 1'b0;
      frame_start = 1'b0;
      de  = (k >= 7) && (k < 7 + nde);
      rst = (rst_at != 0) && (k == rst_at);
    end
    de  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    de  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (text_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_text_addr: got %h expected 0000", text_addr); end
    n_checks++; if (font_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_font_addr: got %h expected 0000", font_addr); end
    n_checks++; if (pix_out !== 4'h0) begin n_fail++; $display("FAIL reset_pix_out: got %h expected 0", pix_out); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL prearm_pix_valid: got %b expected 0", pix_valid); end
    n_checks++; if (font_addr !== 16'h0000) begin n_fail++; $display("FAIL prearm_no_fetch: got %h expected 0000", font_addr); end
    de = 1'b0;
  endtask

  task automatic test_first_line();
    logic [3:0] e [0:15];
    e = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2,
          4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    drive_line(16, 1'b0, 0);
    n_checks++; if (ta_h[2] !== 16'h0000) begin n_fail++; $display("FAIL first_text_addr0: got %h expected 0000", ta_h[2]); end
    n_checks++; if (fa_h[3] !== 16'h0104) begin n_fail++; $display("FAIL first_font_addr0: got %h expected 0104", fa_h[3]); end
    n_checks++; if (ta_h[8] !== 16'h0000) begin n_fail++; $display("FAIL first_text_addr_hold: got %h expected 0000", ta_h[8]); end
    n_checks++; if (ta_h[9] !== 16'h0001) begin n_fail++; $display("FAIL first_text_addr1: got %h expected 0001", ta_h[9]); end
    n_checks++; if (fa_h[10] !== 16'h0108) begin n_fail++; $display("FAIL first_font_addr1: got %h expected 0108", fa_h[10]); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (px_h[8+i] !== e[i] || pv_h[8+i] !== 1'b1) begin n_fail++; $display("FAIL first_pix[%0d]: got %h/%b expected %h/1", i, px_h[8+i], pv_h[8+i], e[i]); end
    end
    n_checks++; if (pv_h[24] !== 1'b0) begin n_fail++; $display("FAIL first_valid_end: got %b expected 0", pv_h[24]); end
  endtask

  task automatic test_odd_scan();
    logic [3:0] e [0:15];
    e = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
          4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1};
    drive_line(16, 1'b0, 0);
    n_checks++; if (fa_h[3] !== 16'h0104) begin n_fail++; $display("FAIL odd_font_addr0: got %h expected 0104", fa_h[3]); end
    n_checks++; if (fa_h[10] !== 16'h0108) begin n_fail++; $display("FAIL odd_font_addr1: got %h expected 0108", fa_h[10]); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (px_h[8+i] !== e[i]) begin n_fail++; $display("FAIL odd_pix[%0d]: got %h expected %h", i, px_h[8+i], e[i]); end
    end
  endtask

  task automatic test_row_wrap();
    logic [15:0] efa;
    repeat (5) drive_line(0, 1'b0, 0);
    drive_line(8, 1'b0, 0);   // scan 7 of row 0
    n_checks++; if (fa_h[3] !== 16'h0107) begin n_fail++; $display("FAIL scan7_font_addr: got %h expected 0107", fa_h[3]); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (px_h[8+i] !== exp_pix(text_mem[0], 3'd7, i)) begin n_fail++; $display("FAIL scan7_pix[%0d]: got %h expected %h", i, px_h[8+i], exp_pix(text_mem[0], 3'd7, i)); end
    end
    drive_line(8, 1'b0, 0);   // scan 0 of row 1
    efa = {6'd0, text_mem[80][7:0], 2'b00};
    n_checks++; if (ta_h[2] !== 16'h0050) begin n_fail++; $display("FAIL wrap_text_addr: got %h expected 0050", ta_h[2]); end
    n_checks++; if (fa_h[3] !== efa) begin n_fail++; $display("FAIL wrap_font_addr: got %h expected %h", fa_h[3], efa); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (px_h[8+i] !== exp_pix(text_mem[80], 3'd0, i)) begin n_fail++; $display("FAIL wrap_pix[%0d]: got %h expected %h", i, px_h[8+i], exp_pix(text_mem[80], 3'd0, i)); end
    end
  endtask

  task automatic test_past_cols();
    logic [15:0] mx;
    drive_line(656, 1'b0, 0);  // row 1, scan 1
    mx = 16'h0000;
    for (int k = 1; k <= 665; k++) if (ta_h[k] > mx) mx = ta_h[k];
    n_checks++; if (mx !== 16'd159) begin n_fail++; $display("FAIL cols_max_text_addr: got %0d expected 159", mx); end
    n_checks++; if (ta_h[633] !== 16'd159) begin n_fail++; $display("FAIL cols_last_fetch: got %0d expected 159", ta_h[633]); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (px_h[640+i] !== exp_pix(text_mem[159], 3'd1, i)) begin n_fail++; $display("FAIL cols_col79_pix[%0d]: got %h expected %h", i, px_h[640+i], exp_pix(text_mem[159], 3'd1, i)); end
    end
    for (int i = 640; i < 656; i++) begin
      n_checks++; if (px_h[8+i] !== 4'h0 || pv_h[8+i] !== 1'b1) begin n_fail++; $display("FAIL cols_blank_pix[%0d]: got %h/%b expected 0/1", i, px_h[8+i], pv_h[8+i]); end
    end
    n_checks++; if (pv_h[664] !== 1'b0) begin n_fail++; $display("FAIL cols_valid_end: got %b expected 0", pv_h[664]); end
  endtask

  task automatic test_past_rows();
    int bad;
    repeat (229) drive_line(0, 1'b0, 0);
    drive_line(0, 1'b0, 0);    // row 29, scan 7
    n_checks++; if (ta_h[2] !== 16'h0910) begin n_fail++; $display("FAIL row29_text_addr: got %h expected 0910", ta_h[2]); end
    drive_line(16, 1'b0, 0);   // row 30
    bad = 0;
    for (int k = 1; k <= 25; k++) if (ta_h[k] !== 16'h0910) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rows_no_fetch: got %0d changed samples expected 0", bad); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (px_h[8+i] !== 4'h0 || pv_h[8+i] !== 1'b1) begin n_fail++; $display("FAIL rows_pix[%0d]: got %h/%b expected 0/1", i, px_h[8+i], pv_h[8+i]); end
    end
    n_checks++; if (pv_h[24] !== 1'b0) begin n_fail++; $display("FAIL rows_valid_end: got %b expected 0", pv_h[24]); end
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [3:0] e [0:7];
    e = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
    drive_line(16, 1'b1, 10);  // frame_start with line_start, rst after 3 pixels
    n_checks++; if (fa_h[3] !== 16'h0104) begin n_fail++; $display("FAIL fsls_font_addr: got %h expected 0104", fa_h[3]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (px_h[8+i] !== e[i] || pv_h[8+i] !== 1'b1) begin n_fail++; $display("FAIL fsls_pix[%0d]: got %h/%b expected %h/1", i, px_h[8+i], pv_h[8+i], e[i]); end
    end
    n_checks++; if (px_h[11] !== 4'h0 || pv_h[11] !== 1'b0) begin n_fail++; $display("FAIL midrst_pix: got %h/%b expected 0/0", px_h[11], pv_h[11]); end
    bad = 0;
    for (int k = 11; k <= 25; k++) if (pv_h[k] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_silent: got %0d valid samples expected 0", bad); end
    n_checks++; if (ta_h[25] !== 16'h0000 || fa_h[25] !== 16'h0000) begin n_fail++; $display("FAIL midrst_addr: got %h/%h expected 0000/0000", ta_h[25], fa_h[25]); end
    drive_line(8, 1'b0, 0);
    n_checks++; if (fa_h[3] !== 16'h0104) begin n_fail++; $display("FAIL resume_font_addr: got %h expected 0104", fa_h[3]); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (px_h[8+i] !== e[i]) begin n_fail++; $display("FAIL resume_pix[%0d]: got %h expected %h", i, px_h[8+i], e[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) text_mem[i] = {4'h3, 4'hC, 8'(i * 7 + 5)};
    for (int i = 0; i < 1024; i++) font_mem[i] = {8'(i ^ 8'h5A), 8'(i * 3 + 1)};
    text_mem[0]     = 16'h2141;
    text_mem[1]     = 16'h2142;
    font_mem[10'h104] = 16'h183C;
    font_mem[10'h108] = 16'hF00F;
    test_reset();
    test_first_line();
    test_odd_scan();
    test_row_wrap();
    test_past_cols();
    test_past_rows();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
